// File: rtl/nand_gate.sv
// Bitwise NAND slice for the ALU logic-operation path.
// Combinational result plus a registered copy with valid/zero/all-ones flags.
module nand_gate #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y_q,
    output logic             q_valid,
    output logic             q_zero,
    output logic             q_ones
);

    logic y_zero;
    logic y_ones;

    // Y must follow A/B at all times, reset included, so it stays outside the register.
    assign Y      = ~(A & B);
    assign y_zero = (Y == '0);
    assign y_ones = &Y;

    always_ff @(posedge clk) begin
        if (rst) begin
            Y_q     <= '0;
            q_valid <= 1'b0;
            q_zero  <= 1'b0;
            q_ones  <= 1'b0;
        end else begin
            Y_q     <= Y;
            q_valid <= 1'b1;
            q_zero  <= y_zero;
            q_ones  <= y_ones;
        end
    end

endmodule

// File: tb/tb_nand_gate.sv
// Directed bench for nand_gate: exhaustive 4-bit NAND, corners, register path,
// reset behaviour, and WIDTH=1 / WIDTH=16 instances against a reference NAND.
module tb_nand_gate;

    logic        clk;
    logic        rst;
    logic [3:0]  a4, b4, y4, yq4;
    logic        v4, z4, o4;
    logic [0:0]  a1, b1, y1, yq1;
    logic        v1, z1, o1;
    logic [15:0] a16, b16, y16, yq16;
    logic        v16, z16, o16;

    int checks = 0;
    int errors = 0;

    nand_gate #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .Y(y4), .A(a4), .B(b4),
        .Y_q(yq4), .q_valid(v4), .q_zero(z4), .q_ones(o4)
    );

    nand_gate #(.WIDTH(1)) dut_w1 (
        .clk(clk), .rst(rst), .Y(y1), .A(a1), .B(b1),
        .Y_q(yq1), .q_valid(v1), .q_zero(z1), .q_ones(o1)
    );

    nand_gate #(.WIDTH(16)) dut_w16 (
        .clk(clk), .rst(rst), .Y(y16), .A(a16), .B(b16),
        .Y_q(yq16), .q_valid(v16), .q_zero(z16), .q_ones(o16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reg4(input string tag, input logic [3:0] ey, input logic ev);
        check({tag, ".Y_q"}, 16'(yq4), 16'(ey));
        check({tag, ".q_valid"}, 16'(v4), 16'(ev));
        check({tag, ".q_zero"}, 16'(z4), 16'(ev && ey == 4'h0));
        check({tag, ".q_ones"}, 16'(o4), 16'(ev && ey == 4'hF));
    endtask

    logic [3:0]  ey4;
    logic [0:0]  ey1;
    logic [15:0] ey16;

    initial begin
        rst = 1'b1;
        a4 = 4'h0;  b4 = 4'h0;
        a1 = 1'b0;  b1 = 1'b0;
        a16 = 16'h0; b16 = 16'h0;

        // Reset state
        tick();
        check_reg4("reset_state", 4'h0, 1'b0);
        check("reset_state.w1.Y_q", 16'(yq1), 16'h0);
        check("reset_state.w16.Y_q", yq16, 16'h0);

        // Reset held two edges with A=3, B=5: Y=E throughout
        a4 = 4'h3; b4 = 4'h5;
        #1 check("rst_hold.Y0", 16'(y4), 16'hE);
        tick();
        check("rst_hold.Y1", 16'(y4), 16'hE);
        check_reg4("rst_hold1", 4'h0, 1'b0);
        tick();
        check("rst_hold.Y2", 16'(y4), 16'hE);
        check_reg4("rst_hold2", 4'h0, 1'b0);
        rst = 1'b0;
        tick();
        check_reg4("rst_release", 4'hE, 1'b1);

        // Corners
        a4 = 4'h0; b4 = 4'h0; #1 check("corner_00", 16'(y4), 16'hF);
        a4 = 4'hF; b4 = 4'hF; #1 check("corner_FF", 16'(y4), 16'h0);
        a4 = 4'hF; b4 = 4'h0; #1 check("corner_F0", 16'(y4), 16'hF);
        a4 = 4'hC; b4 = 4'hA; #1 check("corner_CA", 16'(y4), 16'h7);

        // Register path: all-ones operands, then A drops to 0
        a4 = 4'hF; b4 = 4'hF;
        tick();
        check_reg4("reg_ff", 4'h0, 1'b1);
        a4 = 4'h0;
        #1 check("reg_a0.Y_now", 16'(y4), 16'hF);
        check("reg_a0.Y_q_hold", 16'(yq4), 16'h0);
        tick();
        check_reg4("reg_a0", 4'hF, 1'b1);

        // Exhaustive 4-bit sweep: combinational then registered
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                a4 = 4'(i); b4 = 4'(j);
                ey4 = ~(4'(i) & 4'(j));
                #1 check($sformatf("exh_Y_%0h_%0h", i, j), 16'(y4), 16'(ey4));
                tick();
                check_reg4($sformatf("exh_q_%0h_%0h", i, j), ey4, 1'b1);
            end
        end

        // Mid-stream reset pulse during random stimulus
        for (int k = 0; k < 8; k++) begin
            a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
            ey4 = ~(a4 & b4);
            rst = (k == 4);
            tick();
            check($sformatf("mid_Y_%0d", k), 16'(y4), 16'(ey4));
            if (k == 4) check_reg4("mid_rst", 4'h0, 1'b0);
            else        check_reg4($sformatf("mid_q_%0d", k), ey4, 1'b1);
        end
        rst = 1'b0;

        // WIDTH=1 and WIDTH=16 random
        for (int k = 0; k < 24; k++) begin
            a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1));
            a16 = 16'($urandom); b16 = 16'($urandom);
            if (k == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; end
            if (k == 1) begin a16 = 16'h0000; b16 = 16'h1234; end
            ey1 = ~(a1 & b1);
            ey16 = ~(a16 & b16);
            #1;
            check($sformatf("w1_Y_%0d", k), 16'(y1), 16'(ey1));
            check($sformatf("w16_Y_%0d", k), y16, ey16);
            tick();
            check($sformatf("w1_Yq_%0d", k), 16'(yq1), 16'(ey1));
            check($sformatf("w1_zero_%0d", k), 16'(z1), 16'(ey1 == 1'b0));
            check($sformatf("w1_ones_%0d", k), 16'(o1), 16'(ey1 == 1'b1));
            check($sformatf("w16_Yq_%0d", k), yq16, ey16);
            check($sformatf("w16_zero_%0d", k), 16'(z16), 16'(ey16 == 16'h0));
            check($sformatf("w16_ones_%0d", k), 16'(o16), 16'(ey16 == 16'hFFFF));
            check($sformatf("w16_valid_%0d", k), 16'(v16), 16'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
